// File: rtl/jk_ff_bist_driver.sv
// Built-in self-test driver for a JK flip-flop sharing this block's clock.
// Plays a fixed 8-step {J,K} sequence into the flop under test.
// Predicts each next state with an internal JK model.
// Checks the returned q/qbar and reports pass, a fail count and the first failing step.
module jk_ff_bist_driver #(
  parameter int HOLD_CYCLES = 2  // cycles from a jk update to its compare edge, 2..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q_in,
  input  logic       qbar_in,
  output logic [1:0] jk,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_step
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] RELOAD = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] step;
  logic [3:0] wait_cnt;
  logic       model;
  logic       cmp_edge;
  logic       step_fail;
  logic       last_step;
  logic [2:0] step_inc;
  logic [1:0] jk_inc;

  // Fixed stimulus table: clear, hold, set, hold, toggle, toggle, clear, toggle.
  function automatic logic [1:0] step_jk(input logic [2:0] s);
    case (s)
      3'd0:    step_jk = 2'b01;
      3'd1:    step_jk = 2'b00;
      3'd2:    step_jk = 2'b10;
      3'd3:    step_jk = 2'b00;
      3'd4:    step_jk = 2'b11;
      3'd5:    step_jk = 2'b11;
      3'd6:    step_jk = 2'b01;
      default: step_jk = 2'b11;
    endcase
  endfunction

  // Reference JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic jk_next(input logic m, input logic [1:0] v);
    case (v)
      2'b00:   jk_next = m;
      2'b01:   jk_next = 1'b0;
      2'b10:   jk_next = 1'b1;
      default: jk_next = ~m;
    endcase
  endfunction

  // Case equality makes an X/Z on either returned rail count as a failure.
  assign cmp_edge  = (state == S_RUN) && (wait_cnt == 4'd0);
  assign step_fail = !((q_in === model) && (qbar_in === ~model));
  assign last_step = (step == 3'd7);
  assign step_inc  = step + 3'd1;
  assign jk_inc    = step_jk(step_inc);
  assign done      = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last compare, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cmp_edge && last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stimulus sequencing, hold counting, model update and result bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jk              <= 2'b00;
      busy            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= 4'd0;
      first_fail_step <= 3'd0;
      step            <= 3'd0;
      wait_cnt        <= 4'd0;
      model           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          jk <= 2'b00;
          if (start) begin
            jk              <= step_jk(3'd0);
            model           <= jk_next(model, step_jk(3'd0));
            wait_cnt        <= RELOAD;
            step            <= 3'd0;
            fail_count      <= 4'd0;
            first_fail_step <= 3'd0;
            pass            <= 1'b0;
            busy            <= 1'b1;
          end
        end
        S_RUN: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            if (step_fail) begin
              fail_count <= fail_count + 4'd1;
              if (fail_count == 4'd0) first_fail_step <= step;
            end
            if (!last_step) begin
              step     <= step_inc;
              jk       <= jk_inc;
              model    <= jk_next(model, jk_inc);
              wait_cnt <= RELOAD;
            end else begin
              jk   <= 2'b00;
              busy <= 1'b0;
              pass <= (fail_count == 4'd0) && !step_fail;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_ff_bist_driver.sv
// Bench for jk_ff_bist_driver: two instances (HOLD_CYCLES 2 and 4) each drive a
// behavioural JK flop whose returned q/qbar can be replaced by fault patterns.
module tb_jk_ff_bist_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start2 = 1'b0;
  logic       start4 = 1'b0;
  logic [1:0] jk2, jk4;
  logic       busy2, done2, pass2, busy4, done4, pass4;
  logic [3:0] fc2, fc4;
  logic [2:0] ffs2, ffs4;
  logic       q2, qb2, q4, qb4;
  logic       fq2 = 1'b0;
  logic       fq4 = 1'b0;
  int         cnt2 = 0;
  int         cnt4 = 0;
  int         mode = 0;  // 0 good, 1 q stuck 0, 2 q stuck 1, 3 qbar tied to q, 4 both X

  int compared = 0;
  int mismatched = 0;

  logic [1:0] exp_jk [8];

  typedef struct {
    int mode;
    int pass;
    int fc;
    int ffs;
  } vec_t;
  vec_t vecs [5];

  jk_ff_bist_driver #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .q_in(q2), .qbar_in(qb2),
    .jk(jk2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(fc2), .first_fail_step(ffs2)
  );

  jk_ff_bist_driver #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .q_in(q4), .qbar_in(qb4),
    .jk(jk4), .busy(busy4), .done(done4), .pass(pass4),
    .fail_count(fc4), .first_fail_step(ffs4)
  );

  always #5 clk = ~clk;

  function automatic logic jk_ref(input logic m, input logic [1:0] v);
    case (v)
      2'b00:   jk_ref = m;
      2'b01:   jk_ref = 1'b0;
      2'b10:   jk_ref = 1'b1;
      default: jk_ref = ~m;
    endcase
  endfunction

  // Flops under test: each samples jk once per step, on the edge after the driver updates it.
  always @(posedge clk) begin
    if (!busy2) cnt2 <= 0;
    else begin
      cnt2 <= (cnt2 == 1) ? 0 : cnt2 + 1;
      if (cnt2 == 0) fq2 <= jk_ref(fq2, jk2);
    end
  end

  always @(posedge clk) begin
    if (!busy4) cnt4 <= 0;
    else begin
      cnt4 <= (cnt4 == 3) ? 0 : cnt4 + 1;
      if (cnt4 == 0) fq4 <= jk_ref(fq4, jk4);
    end
  end

  // Fault injection on the returned rails.
  always_comb begin
    q2 = fq2; qb2 = ~fq2; q4 = fq4; qb4 = ~fq4;
    case (mode)
      1: begin q2 = 1'b0; qb2 = 1'b1; q4 = 1'b0; qb4 = 1'b1; end
      2: begin q2 = 1'b1; qb2 = 1'b0; q4 = 1'b1; qb4 = 1'b0; end
      3: begin qb2 = fq2; qb4 = fq4; end
      4: begin q2 = 1'bx; qb2 = 1'bx; q4 = 1'bx; qb4 = 1'bx; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One run: pulse start, then observe every cycle at the falling edge.
  task automatic run(input int h, input bit extra, output int busy_n, output int done_n,
                     output int done_at, output int jk_bad);
    logic [1:0] j, ej;
    logic b, d;
    busy_n = 0; done_n = 0; done_at = -1; jk_bad = 0;
    @(negedge clk);
    if (h == 2) start2 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start4 = 1'b0;
    for (int c = 0; c < 8 * h + 4; c++) begin
      j = (h == 2) ? jk2 : jk4;
      b = (h == 2) ? busy2 : busy4;
      d = (h == 2) ? done2 : done4;
      if (b === 1'b1) busy_n++;
      if (d === 1'b1) begin done_n++; done_at = c; end
      ej = (c < 8 * h) ? exp_jk[c / h] : 2'b00;
      if (j !== ej) jk_bad++;
      if (extra && (c == 5 || c == 18 || c == 8 * h)) begin
        if (h == 2) start2 = 1'b1; else start4 = 1'b1;
      end else begin
        start2 = 1'b0; start4 = 1'b0;
      end
      @(negedge clk);
    end
    start2 = 1'b0; start4 = 1'b0;
  endtask

  initial begin
    int bn, dn, da, jb;
    exp_jk = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11};
    vecs[0] = '{mode: 0, pass: 1, fc: 0, ffs: 0};
    vecs[1] = '{mode: 1, pass: 0, fc: 4, ffs: 2};
    vecs[2] = '{mode: 2, pass: 0, fc: 4, ffs: 0};
    vecs[3] = '{mode: 3, pass: 0, fc: 8, ffs: 0};
    vecs[4] = '{mode: 4, pass: 0, fc: 8, ffs: 0};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_jk", 32'(jk2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_done", 32'(done2), 32'd0);
    check("rst_pass", 32'(pass2), 32'd0);
    check("rst_fc", 32'(fc2), 32'd0);
    check("rst_ffs", 32'(ffs2), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      run(2, 1'b0, bn, dn, da, jb);
      check($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'd16);
      check($sformatf("v%0d_done_pulses", i), 32'(dn), 32'd1);
      check($sformatf("v%0d_done_at", i), 32'(da), 32'd16);
      check($sformatf("v%0d_jk_errs", i), 32'(jb), 32'd0);
      check($sformatf("v%0d_pass", i), 32'(pass2), 32'(vecs[i].pass));
      check($sformatf("v%0d_fail_count", i), 32'(fc2), 32'(vecs[i].fc));
      check($sformatf("v%0d_first_fail", i), 32'(ffs2), 32'(vecs[i].ffs));
    end

    // Abort during step 4 with failures already counted, then a clean rerun.
    mode = 2;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_jk_step4", 32'(jk2), 32'(2'b11));
    check("abort_fc_before", 32'(fc2), 32'd2);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy2), 32'd0);
    check("abort_jk", 32'(jk2), 32'd0);
    check("abort_fc", 32'(fc2), 32'd0);
    check("abort_pass", 32'(pass2), 32'd0);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done2 !== 1'b0) dn++;
      if (c == 2) rst = 1'b1;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    mode = 0;
    run(2, 1'b0, bn, dn, da, jb);
    check("rerun_done_pulses", 32'(dn), 32'd1);
    check("rerun_jk_errs", 32'(jb), 32'd0);
    check("rerun_pass", 32'(pass2), 32'd1);
    check("rerun_fc", 32'(fc2), 32'd0);

    // Longer hold with stray start pulses mid-run and during DONE.
    mode = 0;
    run(4, 1'b1, bn, dn, da, jb);
    check("h4_busy_cycles", 32'(bn), 32'd32);
    check("h4_done_pulses", 32'(dn), 32'd1);
    check("h4_done_at", 32'(da), 32'd32);
    check("h4_jk_errs", 32'(jb), 32'd0);
    check("h4_pass", 32'(pass4), 32'd1);
    check("h4_fc", 32'(fc4), 32'd0);
    check("h4_ffs", 32'(ffs4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
